cave_fifo_fill_ctrl: RTL and testbench

- Sequences a 32-entry x 64-bit FIFO queue from a burst-read memory port (DDR/SDRAM arbiter side).
- Takes a job (byte base address, word count), splits it into bursts, and issues a burst only when the FIFO has room for the whole burst.
- Streams returned words into the FIFO enqueue port. Sits between the memory arbiter and the FIFO feeding the tile/sprite/frame-buffer consumers.

---
 rtl/cave_mem_pkg.sv | 22 ++
 rtl/cave_burst_splitter.sv | 62 ++++++
 rtl/cave_fifo_fill_ctrl.sv | 153 +++++++++++++++
 tb/tb_cave_fifo_fill_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cave_mem_pkg.sv
// Shared types and constants for the memory-to-FIFO fill path.
package cave_mem_pkg;

  localparam int unsigned WORD_BYTES      = 8;
  localparam int unsigned WORD_SHIFT      = 3;
  localparam int unsigned BURST_LEN_WIDTH = 8;
  localparam int unsigned MEM_ADDR_WIDTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_CHECK,
    ST_REQ,
    ST_DATA
  } fill_state_t;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0]  addr;
    logic [BURST_LEN_WIDTH-1:0] len;
  } burst_req_t;

endpackage

// File: rtl/cave_burst_splitter.sv
// Address / remaining-word bookkeeping that carves a job into bursts.
module cave_burst_splitter
  import cave_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [COUNT_WIDTH-1:0] load_count,
  input  logic                   step,
  output burst_req_t             burst,
  output logic                   last,
  output logic                   zero
);

  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]     rem_q, rem_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic                       last_q, zero_q;

  // Next address/remaining: a new job overrides the step of the current one.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_addr & ~ADDR_WIDTH'(WORD_BYTES - 1);
      rem_d  = load_count;
    end else if (step) begin
      addr_d = addr_q + (ADDR_WIDTH'(len_q) << WORD_SHIFT);
      rem_d  = rem_q - COUNT_WIDTH'(len_q);
    end
    len_d = (rem_d < COUNT_WIDTH'(BURST_LEN)) ? BURST_LEN_WIDTH'(rem_d)
                                               : BURST_LEN_WIDTH'(BURST_LEN);
  end

  // Bookkeeping registers; burst length and flags are precomputed from the next remaining count.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
      len_q  <= '0;
      last_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      len_q  <= len_d;
      last_q <= (rem_d <= COUNT_WIDTH'(BURST_LEN));
      zero_q <= (rem_d == '0);
    end
  end

  assign burst.addr = MEM_ADDR_WIDTH'(addr_q);
  assign burst.len  = len_q;
  assign last       = last_q;
  assign zero       = zero_q;

endmodule

// File: rtl/cave_fifo_fill_ctrl.sv
// Fills a FIFO from a burst-read memory port, one burst outstanding at a time.
module cave_fifo_fill_ctrl
  import cave_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = MEM_ADDR_WIDTH,
  parameter int unsigned BURST_LEN        = 8,
  parameter int unsigned DEPTH            = 32,
  parameter int unsigned COUNT_WIDTH      = 16,
  parameter int unsigned FIFO_COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [COUNT_WIDTH-1:0]      word_count,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [BURST_LEN_WIDTH-1:0]  mem_burst_len,
  input  logic                        mem_rsp_valid,
  input  logic [63:0]                 mem_rsp_data,
  output logic                        fifo_enq_valid,
  output logic [63:0]                 fifo_enq_bits,
  input  logic [FIFO_COUNT_WIDTH-1:0] fifo_count,
  output logic                        fifo_flush
);

  fill_state_t                state_q, state_d;
  logic [BURST_LEN_WIDTH-1:0] beats_q, beats_d;
  logic                       drain_q, drain_d;
  logic                       done_d;
  logic                       step_c;
  logic                       busy_q, done_q, flush_q, req_valid_q;
  burst_req_t                 req_q;
  burst_req_t                 burst;
  logic                       last, zero;
  logic                       space_ok;

  cave_burst_splitter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_splitter (
    .clock     (clock),
    .reset     (reset),
    .load      (start),
    .load_addr (base_addr),
    .load_count(word_count),
    .step      (step_c),
    .burst     (burst),
    .last      (last),
    .zero      (zero)
  );

  assign space_ok = (32'(fifo_count) + 32'(burst.len)) <= 32'(DEPTH);

  // Next-state logic: sequencing, space check, abort and drain handling.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FLUSH;
          drain_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (start)      state_d = ST_FLUSH;
        else if (zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (start)         state_d = ST_FLUSH;
        else if (space_ok) state_d = ST_REQ;
      end
      ST_REQ: begin
        // A request accepted in the abort cycle is still in flight and must be drained.
        if (mem_req_ready) begin
          state_d = ST_DATA;
          beats_d = req_q.len;
          drain_d = start;
        end else if (start) begin
          state_d = ST_FLUSH;
        end
      end
      ST_DATA: begin
        if (mem_rsp_valid) begin
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd1) begin
            drain_d = 1'b0;
            if (drain_q || start) begin
              state_d = ST_FLUSH;
            end else begin
              step_c = 1'b1;
              if (last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_CHECK;
              end
            end
          end else if (start) begin
            drain_d = 1'b1;
          end
        end else if (start) begin
          drain_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beats_q     <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flush_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      drain_q     <= drain_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
      flush_q     <= (state_d == ST_FLUSH);
      req_valid_q <= (state_d == ST_REQ);
      if (state_d == ST_REQ && state_q != ST_REQ) req_q <= burst;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign fifo_flush     = flush_q;
  assign mem_req_valid  = req_valid_q;
  assign mem_addr       = ADDR_WIDTH'(req_q.addr);
  assign mem_burst_len  = req_q.len;
  assign fifo_enq_valid = (state_q == ST_DATA) && !drain_q && mem_rsp_valid;
  assign fifo_enq_bits  = mem_rsp_data;

endmodule

// File: tb/tb_cave_fifo_fill_ctrl.sv
// Directed self-checking bench for cave_fifo_fill_ctrl.
module tb_cave_fifo_fill_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic [7:0]  mem_burst_len;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        fifo_enq_valid;
  logic [63:0] fifo_enq_bits;
  logic [5:0]  fifo_count;
  logic        fifo_flush;

  int checks = 0;
  int errors = 0;
  int wseq   = 0;

  // FIFO occupancy model and event counters
  int occ = 0;
  int occ_val = 0;
  bit occ_set = 1'b0;
  bit deq_en  = 1'b0;
  int flush_cnt = 0, done_cnt = 0, acc_cnt = 0, reqv_cnt = 0, enq_cnt = 0;

  cave_fifo_fill_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_burst_len (mem_burst_len),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .fifo_enq_valid(fifo_enq_valid),
    .fifo_enq_bits (fifo_enq_bits),
    .fifo_count    (fifo_count),
    .fifo_flush    (fifo_flush)
  );

  always #5 clock = ~clock;

  assign fifo_count = 6'(occ);

  always @(posedge clock) begin
    if (occ_set)             occ <= occ_val;
    else if (fifo_flush)     occ <= 0;
    else                     occ <= occ + (fifo_enq_valid ? 1 : 0) - ((deq_en && occ != 0) ? 1 : 0);
    if (fifo_flush)                    flush_cnt <= flush_cnt + 1;
    if (done)                          done_cnt  <= done_cnt + 1;
    if (mem_req_valid && mem_req_ready) acc_cnt  <= acc_cnt + 1;
    if (mem_req_valid)                 reqv_cnt  <= reqv_cnt + 1;
    if (fifo_enq_valid)                enq_cnt   <= enq_cnt + 1;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [31:0] a, input logic [15:0] n);
    start = 1'b1; base_addr = a; word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req_valid && n < 80) begin tick(); n++; end
    chk("req_seen", 64'(mem_req_valid), 64'd1);
  endtask

  // Wait for a request, check it, stall it, accept it and stream its beats.
  task automatic serve(input logic [31:0] ea, input logic [7:0] el, input int stall);
    wait_req();
    chk("req_addr", 64'(mem_addr), 64'(ea));
    chk("req_len", 64'(mem_burst_len), 64'(el));
    for (int s = 0; s < stall; s++) begin
      chk("req_hold", {mem_req_valid, mem_addr, mem_burst_len}, {1'b1, ea, el});
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < int'(el); i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hC0DE_0000_0000_0000 | 64'(wseq);
      #1;
      chk("enq_valid", 64'(fifo_enq_valid), 64'd1);
      chk("enq_bits", fifo_enq_bits, 64'hC0DE_0000_0000_0000 | 64'(wseq));
      wseq++;
      tick();
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic basic_job();
    int f0, d0, e0, a0;
    f0 = flush_cnt; d0 = done_cnt; e0 = enq_cnt; a0 = acc_cnt;
    deq_en = 1'b1;
    kick(32'h1000, 16'd20);
    chk("basic_flush", 64'(fifo_flush), 64'd1);
    chk("basic_busy", 64'(busy), 64'd1);
    serve(32'h1000, 8'd8, 0);
    serve(32'h1040, 8'd8, 0);
    serve(32'h1080, 8'd4, 0);
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_busy_fall", 64'(busy), 64'd0);
    tick();
    chk("basic_done_pulse", 64'(done), 64'd0);
    chk("basic_enq_cnt", 64'(enq_cnt - e0), 64'd20);
    chk("basic_flush_cnt", 64'(flush_cnt - f0), 64'd1);
    chk("basic_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("basic_acc_cnt", 64'(acc_cnt - a0), 64'd3);
  endtask

  initial begin
    int f0, d0, e0, a0, r0;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_flush", 64'(fifo_flush), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_len", 64'(mem_burst_len), 64'd0);
    chk("rst_enq", 64'(fifo_enq_valid), 64'd0);

    // Basic job with a draining consumer
    basic_job();

    // Backpressure: fill to 32 with no dequeue
    deq_en = 1'b0;
    e0 = enq_cnt;
    kick(32'h4000, 16'd32);
    serve(32'h4000, 8'd8, 0);
    serve(32'h4040, 8'd8, 0);
    serve(32'h4080, 8'd8, 0);
    serve(32'h40C0, 8'd8, 0);
    chk("bp_done", 64'(done), 64'd1);
    chk("bp_enq_cnt", 64'(enq_cnt - e0), 64'd32);
    tick();
    chk("bp_fifo_full", 64'(fifo_count), 64'd32);

    // FIFO held at 26 then 25: no room for 8 words
    occ_set = 1'b1; occ_val = 26;
    r0 = reqv_cnt;
    kick(32'h5000, 16'd8);
    repeat (10) tick();
    chk("bp_wait26", 64'(reqv_cnt - r0), 64'd0);
    occ_val = 25;
    repeat (5) tick();
    chk("bp_wait25", 64'(reqv_cnt - r0), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    occ_val = 24;
    serve(32'h5000, 8'd8, 0);
    chk("bp2_done", 64'(done), 64'd1);
    occ_set = 1'b0;
    tick();

    // Request stall; unaligned base has its low bits dropped
    deq_en = 1'b1;
    a0 = acc_cnt;
    kick(32'h600F, 16'd3);
    serve(32'h6008, 8'd3, 10);
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_acc_cnt", 64'(acc_cnt - a0), 64'd1);
    tick();

    // Zero-length job
    f0 = flush_cnt; r0 = reqv_cnt;
    kick(32'h7000, 16'd0);
    chk("zero_flush", 64'(fifo_flush), 64'd1);
    tick();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_flush_off", 64'(fifo_flush), 64'd0);
    tick();
    chk("zero_flush_cnt", 64'(flush_cnt - f0), 64'd1);
    chk("zero_no_req", 64'(reqv_cnt - r0), 64'd0);

    // Abort in DATA after 3 of 8 beats
    f0 = flush_cnt; d0 = done_cnt; e0 = enq_cnt;
    kick(32'h8000, 16'd16);
    wait_req();
    chk("abort_req_addr", 64'(mem_addr), 64'h8000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hAAAA_0000_0000_0000 | 64'(i);
      tick();
    end
    mem_rsp_valid = 1'b0;
    kick(32'h2000, 16'd4);
    for (int i = 0; i < 5; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBBBB_0000_0000_0000 | 64'(i);
      #1;
      chk("abort_drain_enq", 64'(fifo_enq_valid), 64'd0);
      tick();
    end
    mem_rsp_valid = 1'b0;
    chk("abort_flush", 64'(fifo_flush), 64'd1);
    serve(32'h2000, 8'd4, 0);
    chk("abort_done", 64'(done), 64'd1);
    tick();
    chk("abort_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("abort_enq_cnt", 64'(enq_cnt - e0), 64'd7);
    chk("abort_flush_cnt", 64'(flush_cnt - f0), 64'd2);

    // Reset while a request is pending
    kick(32'h9000, 16'd20);
    wait_req();
    reset = 1'b1;
    mem_rsp_valid = 1'b1;
    tick();
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("mrst_addr", 64'(mem_addr), 64'd0);
    chk("mrst_len", 64'(mem_burst_len), 64'd0);
    chk("mrst_flush", 64'(fifo_flush), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_enq", 64'(fifo_enq_valid), 64'd0);
    reset = 1'b0;
    mem_rsp_valid = 1'b0;
    tick();
    basic_job();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
